// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
// Contents: FSM state enum, instruction class enum, alu_control codes,
// opcode/funct constants and alu_b_sel encodings.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP = 3'd0,
    CLS_ALU = 3'd1,
    CLS_LW  = 3'd2,
    CLS_SW  = 3'd3,
    CLS_BEQ = 3'd4,
    CLS_BNE = 3'd5,
    CLS_J   = 3'd6,
    CLS_JR  = 3'd7
  } instr_class_e;

  // ALU operation codes
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_XOR   = 4'b0010;
  localparam logic [3:0] ALU_LUI   = 4'b0011;
  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_PASSA = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SLLV  = 4'b1010;
  localparam logic [3:0] ALU_SRLV  = 4'b1011;
  localparam logic [3:0] ALU_SRA   = 4'b1100;
  localparam logic [3:0] ALU_SRAV  = 4'b1101;
  localparam logic [3:0] ALU_SLT   = 4'b1110;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // ALU B operand select
  localparam logic [1:0] BSEL_RT   = 2'b00;
  localparam logic [1:0] BSEL_SIMM = 2'b01;
  localparam logic [1:0] BSEL_ZIMM = 2'b10;

endpackage

// File: rtl/mips_cpu_decode.sv
// Combinational instruction decoder.
// Ports: instr_i (instruction register) -> alu_control_o, alu_b_sel_o,
// reg_dst_o (1 = rd), wb_sel_o (1 = memory data), instr_class_o.
// Unknown opcodes/functs decode to CLS_NOP with every field zero.
module mips_cpu_decode
  import mips_cpu_pkg::*;
(
  input  logic [31:0]  instr_i,
  output logic [3:0]   alu_control_o,
  output logic [1:0]   alu_b_sel_o,
  output logic         reg_dst_o,
  output logic         wb_sel_o,
  output instr_class_e instr_class_o
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_instr_bits;

  assign opcode = instr_i[31:26];
  assign funct  = instr_i[5:0];
  // Register/immediate fields belong to the datapath.
  assign unused_instr_bits = ^instr_i[25:6];

  always_comb begin
    alu_control_o = ALU_AND;
    alu_b_sel_o   = BSEL_RT;
    reg_dst_o     = 1'b0;
    wb_sel_o      = 1'b0;
    instr_class_o = CLS_NOP;
    case (opcode)
      OP_RTYPE: begin
        instr_class_o = CLS_ALU;
        reg_dst_o     = 1'b1;
        case (funct)
          FN_ADDU: alu_control_o = ALU_ADD;
          FN_SUBU: alu_control_o = ALU_SUB;
          FN_AND:  alu_control_o = ALU_AND;
          FN_OR:   alu_control_o = ALU_OR;
          FN_XOR:  alu_control_o = ALU_XOR;
          FN_SLT:  alu_control_o = ALU_SLT;
          FN_SLTU: alu_control_o = ALU_SLTU;
          FN_SLL:  alu_control_o = ALU_SLL;
          FN_SRL:  alu_control_o = ALU_SRL;
          FN_SRA:  alu_control_o = ALU_SRA;
          FN_SLLV: alu_control_o = ALU_SLLV;
          FN_SRLV: alu_control_o = ALU_SRLV;
          FN_SRAV: alu_control_o = ALU_SRAV;
          FN_JR: begin
            // rs passes through the ALU so it can feed the target register
            alu_control_o = ALU_PASSA;
            instr_class_o = CLS_JR;
            reg_dst_o     = 1'b0;
          end
          default: begin
            instr_class_o = CLS_NOP;
            reg_dst_o     = 1'b0;
          end
        endcase
      end
      OP_ADDIU: begin alu_control_o = ALU_ADD;  alu_b_sel_o = BSEL_SIMM; instr_class_o = CLS_ALU; end
      OP_SLTI:  begin alu_control_o = ALU_SLT;  alu_b_sel_o = BSEL_SIMM; instr_class_o = CLS_ALU; end
      OP_SLTIU: begin alu_control_o = ALU_SLTU; alu_b_sel_o = BSEL_SIMM; instr_class_o = CLS_ALU; end
      OP_ANDI:  begin alu_control_o = ALU_AND;  alu_b_sel_o = BSEL_ZIMM; instr_class_o = CLS_ALU; end
      OP_ORI:   begin alu_control_o = ALU_OR;   alu_b_sel_o = BSEL_ZIMM; instr_class_o = CLS_ALU; end
      OP_XORI:  begin alu_control_o = ALU_XOR;  alu_b_sel_o = BSEL_ZIMM; instr_class_o = CLS_ALU; end
      OP_LUI:   begin alu_control_o = ALU_LUI;  alu_b_sel_o = BSEL_ZIMM; instr_class_o = CLS_ALU; end
      OP_LW: begin
        alu_control_o = ALU_ADD;
        alu_b_sel_o   = BSEL_SIMM;
        wb_sel_o      = 1'b1;
        instr_class_o = CLS_LW;
      end
      OP_SW:  begin alu_control_o = ALU_ADD; alu_b_sel_o = BSEL_SIMM; instr_class_o = CLS_SW; end
      // Branches compare rs - rt; alu_zero is read back in WB
      OP_BEQ: begin alu_control_o = ALU_SUB; instr_class_o = CLS_BEQ; end
      OP_BNE: begin alu_control_o = ALU_SUB; instr_class_o = CLS_BNE; end
      OP_J:   instr_class_o = CLS_J;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_cpu_control_fsm.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> WB.
// Inputs: clk, reset (sync, active-high), instr, alu_zero, reg_a_zero,
// waitrequest. Outputs: memory strobes/address select, ir_write, ALU
// control and B select, register-file write controls, PC update controls,
// target_write and active. Branches/jumps have one delay slot; JR to
// address 0 halts after the delay slot retires.
module mips_cpu_control_fsm
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        reg_a_zero,
  input  logic        waitrequest,
  output logic        mem_read,
  output logic        mem_write,
  output logic        addr_sel,
  output logic        ir_write,
  output logic [3:0]  alu_control,
  output logic [1:0]  alu_b_sel,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        wb_sel,
  output logic        pc_write,
  output logic        pc_src,
  output logic        target_write,
  output logic        active
);

  state_e       state_q, state_d;
  logic         branch_pending_q, branch_pending_d;
  logic         halt_pending_q, halt_pending_d;
  // Low from the edge that samples reset until the edge after release, so
  // strobes drop one edge after reset rises and nothing moves while held.
  logic         run_q;

  logic [3:0]   dec_alu_control;
  logic [1:0]   dec_alu_b_sel;
  logic         dec_reg_dst;
  logic         dec_wb_sel;
  instr_class_e dec_class;

  mips_cpu_decode u_decode (
    .instr_i       (instr),
    .alu_control_o (dec_alu_control),
    .alu_b_sel_o   (dec_alu_b_sel),
    .reg_dst_o     (dec_reg_dst),
    .wb_sel_o      (dec_wb_sel),
    .instr_class_o (dec_class)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_FETCH;
      branch_pending_q <= 1'b0;
      halt_pending_q   <= 1'b0;
      run_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      branch_pending_q <= branch_pending_d;
      halt_pending_q   <= halt_pending_d;
      run_q            <= 1'b1;
    end
  end

  always_comb begin
    state_d          = state_q;
    branch_pending_d = branch_pending_q;
    halt_pending_d   = halt_pending_q;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    addr_sel         = 1'b0;
    ir_write         = 1'b0;
    alu_control      = ALU_AND;
    alu_b_sel        = BSEL_RT;
    reg_write        = 1'b0;
    reg_dst          = 1'b0;
    wb_sel           = 1'b0;
    pc_write         = 1'b0;
    pc_src           = 1'b0;
    target_write     = 1'b0;
    active           = (state_q != ST_HALT);

    if (run_q) begin
      case (state_q)
        ST_FETCH: begin
          mem_read = 1'b1;
          if (!waitrequest) begin
            // The fetch address was the old PC, so a pending target lands
            // here while the delay-slot instruction is being latched.
            ir_write         = 1'b1;
            pc_write         = 1'b1;
            pc_src           = branch_pending_q;
            branch_pending_d = 1'b0;
            state_d          = ST_DECODE;
          end
        end
        ST_DECODE: state_d = ST_EXEC;
        ST_EXEC: begin
          alu_control = dec_alu_control;
          alu_b_sel   = dec_alu_b_sel;
          state_d     = (dec_class == CLS_LW || dec_class == CLS_SW) ? ST_MEM : ST_WB;
        end
        ST_MEM: begin
          addr_sel = 1'b1;
          if (dec_class == CLS_LW) mem_read = 1'b1;
          else                     mem_write = 1'b1;
          if (!waitrequest) begin
            // A store retires here, so it also honours a pending halt
            if (dec_class == CLS_LW) state_d = ST_WB;
            else                     state_d = halt_pending_q ? ST_HALT : ST_FETCH;
          end
        end
        ST_WB: begin
          reg_dst = dec_reg_dst;
          wb_sel  = dec_wb_sel;
          case (dec_class)
            CLS_ALU, CLS_LW: reg_write = 1'b1;
            CLS_BEQ: if (alu_zero)  begin target_write = 1'b1; branch_pending_d = 1'b1; end
            CLS_BNE: if (!alu_zero) begin target_write = 1'b1; branch_pending_d = 1'b1; end
            CLS_J:   begin target_write = 1'b1; branch_pending_d = 1'b1; end
            CLS_JR: begin
              if (reg_a_zero) halt_pending_d = 1'b1;
              else begin target_write = 1'b1; branch_pending_d = 1'b1; end
            end
            default: ;
          endcase
          // halt_pending_q is only already set when this is the delay slot
          state_d = halt_pending_q ? ST_HALT : ST_FETCH;
        end
        ST_HALT: ;
        default: state_d = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_control_fsm.sv
module tb_mips_cpu_control_fsm;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        alu_zero, reg_a_zero, waitrequest;
  logic        mem_read, mem_write, addr_sel, ir_write;
  logic [3:0]  alu_control;
  logic [1:0]  alu_b_sel;
  logic        reg_write, reg_dst, wb_sel, pc_write, pc_src, target_write, active;

  mips_cpu_control_fsm dut (
    .clk(clk), .reset(reset), .instr(instr), .alu_zero(alu_zero),
    .reg_a_zero(reg_a_zero), .waitrequest(waitrequest),
    .mem_read(mem_read), .mem_write(mem_write), .addr_sel(addr_sel),
    .ir_write(ir_write), .alu_control(alu_control), .alu_b_sel(alu_b_sel),
    .reg_write(reg_write), .reg_dst(reg_dst), .wb_sel(wb_sel),
    .pc_write(pc_write), .pc_src(pc_src), .target_write(target_write),
    .active(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int C_NOP = 0, C_ALU_R = 1, C_ALU_I = 2, C_LW = 3, C_SW = 4,
                 C_BEQ = 5, C_BNE = 6, C_J = 7, C_JR = 8;

  int  n_checks = 0;
  int  n_errors = 0;
  int  txn_count = 0;
  bit  m_branch = 0;   // model: target captured, applies at next fetch
  bit  m_halt = 0;     // model: JR $0 seen, halt after delay slot

  // Decode tables straight from the opcode/funct map: {valid, alu} and {valid, bsel, alu}
  logic [4:0] fn_tab [64];
  logic [6:0] op_tab [64];
  logic [5:0] r_functs [13] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B,
                                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
  logic [5:0] i_ops [7]     = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
  logic [5:0] bad_ops [6]   = '{6'h01, 6'h03, 6'h06, 6'h10, 6'h20, 6'h3F};
  logic [5:0] bad_fns [4]   = '{6'h01, 6'h05, 6'h09, 6'h3F};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_decode(input logic [31:0] ins, output int cls,
                              output logic [3:0] alu, output logic [1:0] bsel);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    cls = C_NOP; alu = 4'b0; bsel = 2'b0;
    if (op == 6'h00) begin
      if (fn_tab[fn][4]) begin
        alu = fn_tab[fn][3:0];
        cls = (fn == 6'h08) ? C_JR : C_ALU_R;
      end
    end else if (op_tab[op][6]) begin
      alu  = op_tab[op][3:0];
      bsel = op_tab[op][5:4];
      case (op)
        6'h23:   cls = C_LW;
        6'h2B:   cls = C_SW;
        6'h04:   cls = C_BEQ;
        6'h05:   cls = C_BNE;
        6'h02:   cls = C_J;
        default: cls = C_ALU_I;
      endcase
    end
  endtask

  function automatic logic [31:0] rand_instr(input bit allow_branch);
    int kind;
    logic [31:0] body;
    kind = $urandom_range(0, 9);
    body = $urandom;
    if (!allow_branch && kind >= 5 && kind <= 8) kind = 0;
    case (kind)
      0, 1:    return {6'h00, body[25:6], r_functs[$urandom_range(0, 12)]};
      2, 3:    return {i_ops[$urandom_range(0, 6)], body[25:0]};
      4:       return {($urandom_range(0, 1) != 0) ? 6'h23 : 6'h2B, body[25:0]};
      5, 8:    return {($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05, body[25:0]};
      6:       return {6'h02, body[25:0]};
      7:       return {6'h00, body[25:6], 6'h08};
      default: begin
        if ($urandom_range(0, 1) != 0) return {bad_ops[$urandom_range(0, 5)], body[25:0]};
        return {6'h00, body[25:6], bad_fns[$urandom_range(0, 3)]};
      end
    endcase
  endfunction

  // Entered at posedge+1 of a cycle in which the DUT is fetching; returns at
  // posedge+1 of the first cycle of the next instruction (or of HALT).
  task automatic run_instr(input logic [31:0] ins, input int fs, input int ms,
                           input logic az, input logic raz);
    int cls, e_cycles, fd, acc;
    logic [3:0] e_alu, got_alu;
    logic [1:0] e_bsel, got_bsel;
    logic [2:0] cur_acc, prev_acc;
    bit e_tw, e_halt, e_rw, done, left_fetch;
    int n_cyc, n_fetch, n_mrd, n_mwr, n_ir, n_pcw, n_rw, n_tw;
    logic got_pcsrc, got_rdst, got_wbsel;
    model_decode(ins, cls, e_alu, e_bsel);
    e_cycles = 4 + ((cls == C_LW) ? 1 : 0) + fs + ((cls == C_LW || cls == C_SW) ? ms : 0);
    e_tw = (cls == C_BEQ && az) || (cls == C_BNE && !az) || (cls == C_J) || (cls == C_JR && !raz);
    e_rw = (cls == C_ALU_R) || (cls == C_ALU_I) || (cls == C_LW);
    e_halt = m_halt;
    n_cyc = 0; n_fetch = 0; n_mrd = 0; n_mwr = 0; n_ir = 0; n_pcw = 0; n_rw = 0; n_tw = 0;
    got_pcsrc = 0; got_rdst = 0; got_wbsel = 0; got_alu = 0; got_bsel = 0;
    fd = -1; acc = 0; prev_acc = 3'b0; done = 0; left_fetch = 0;
    instr = ins; alu_zero = az; reg_a_zero = raz;
    for (int k = 0; k < 40 && !done; k++) begin
      if (k > 0 && (!active || (left_fetch && mem_read && !addr_sel))) done = 1;
      else begin
        // Memory responder: stall the first fs (fetch) or ms (data) cycles of each access
        cur_acc = {mem_read, mem_write, addr_sel};
        if (mem_read || mem_write) begin
          if (cur_acc != prev_acc) acc = 0;
          waitrequest = (acc < (addr_sel ? ms : fs));
          acc++;
        end else begin
          waitrequest = 1'($urandom_range(0, 1));
        end
        prev_acc = cur_acc;
        @(negedge clk);
        n_cyc++;
        if (mem_read && !addr_sel) n_fetch++; else left_fetch = 1;
        if (addr_sel && mem_read)  n_mrd++;
        if (addr_sel && mem_write) n_mwr++;
        if (ir_write) begin n_ir++; fd = k; end
        if (pc_write) begin n_pcw++; got_pcsrc = pc_src; end
        if (reg_write) begin n_rw++; got_rdst = reg_dst; got_wbsel = wb_sel; end
        if (target_write) n_tw++;
        if (fd >= 0 && k == fd + 2) begin got_alu = alu_control; got_bsel = alu_b_sel; end
        @(posedge clk); #1;
      end
    end
    txn_count++;
    $display("txn %0d instr=%08h fetch_stall=%0d mem_stall=%0d cycles=%0d", txn_count, ins, fs, ms, n_cyc);
    check_val("timeout", done, 1);
    check_val("cycles", n_cyc, e_cycles);
    check_val("fetch_cycles", n_fetch, fs + 1);
    check_val("mem_rd_cycles", n_mrd, (cls == C_LW) ? ms + 1 : 0);
    check_val("mem_wr_cycles", n_mwr, (cls == C_SW) ? ms + 1 : 0);
    check_val("ir_write", n_ir, 1);
    check_val("pc_write", n_pcw, 1);
    check_val("pc_src", got_pcsrc, m_branch);
    check_val("alu_control", got_alu, e_alu);
    check_val("alu_b_sel", got_bsel, e_bsel);
    check_val("reg_write", n_rw, e_rw ? 1 : 0);
    if (e_rw) begin
      check_val("reg_dst", got_rdst, (cls == C_ALU_R) ? 1 : 0);
      check_val("wb_sel", got_wbsel, (cls == C_LW) ? 1 : 0);
    end
    check_val("target_write", n_tw, e_tw ? 1 : 0);
    check_val("active_after", active, e_halt ? 0 : 1);
    m_branch = e_tw;
    if (cls == C_JR && raz) m_halt = 1;
  endtask

  task automatic sync_fetch(input string tag);
    bit ok = 0;
    for (int i = 0; i < 6 && !ok; i++) begin
      if (mem_read && !addr_sel && active) ok = 1;
      else begin @(posedge clk); #1; end
    end
    check_val(tag, ok, 1);
  endtask

  task automatic check_halted();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("halt_no_strobe", {mem_read, mem_write, ir_write, pc_write}, 0);
      check_val("halt_active", active, 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1; waitrequest = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    m_branch = 0; m_halt = 0;
    sync_fetch("reset_sync");
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin fn_tab[i] = 5'h0; op_tab[i] = 7'h0; end
    fn_tab[6'h21] = 5'h14; fn_tab[6'h23] = 5'h15; fn_tab[6'h24] = 5'h10;
    fn_tab[6'h25] = 5'h11; fn_tab[6'h26] = 5'h12; fn_tab[6'h2A] = 5'h1E;
    fn_tab[6'h2B] = 5'h16; fn_tab[6'h00] = 5'h18; fn_tab[6'h02] = 5'h19;
    fn_tab[6'h03] = 5'h1C; fn_tab[6'h04] = 5'h1A; fn_tab[6'h06] = 5'h1B;
    fn_tab[6'h07] = 5'h1D; fn_tab[6'h08] = 5'h17;
    op_tab[6'h09] = {1'b1, 2'b01, 4'b0100}; op_tab[6'h0A] = {1'b1, 2'b01, 4'b1110};
    op_tab[6'h0B] = {1'b1, 2'b01, 4'b0110}; op_tab[6'h23] = {1'b1, 2'b01, 4'b0100};
    op_tab[6'h2B] = {1'b1, 2'b01, 4'b0100}; op_tab[6'h0C] = {1'b1, 2'b10, 4'b0000};
    op_tab[6'h0D] = {1'b1, 2'b10, 4'b0001}; op_tab[6'h0E] = {1'b1, 2'b10, 4'b0010};
    op_tab[6'h0F] = {1'b1, 2'b10, 4'b0011}; op_tab[6'h04] = {1'b1, 2'b00, 4'b0101};
    op_tab[6'h05] = {1'b1, 2'b00, 4'b0101}; op_tab[6'h02] = {1'b1, 2'b00, 4'b0000};

    reset = 1; instr = 0; alu_zero = 0; reg_a_zero = 0; waitrequest = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_strobes", {mem_read, mem_write, ir_write, pc_write, reg_write, target_write}, 0);
    check_val("rst_selects", {addr_sel, alu_control, alu_b_sel, reg_dst, wb_sel, pc_src}, 0);
    check_val("rst_active", active, 1);
    @(posedge clk); #1 reset = 0;
    sync_fetch("init_sync");

    run_instr(32'h00221821, 0, 0, 0, 0);  // ADDU
    run_instr(32'h8C220004, 0, 3, 0, 0);  // LW, 3 data stalls
    run_instr(32'h10220003, 0, 0, 1, 0);  // BEQ taken
    run_instr(32'h34210005, 1, 0, 0, 0);  // ORI in delay slot, pc_src = 1
    run_instr(32'h00221821, 0, 0, 0, 0);  // pc_src back to 0
    run_instr(32'h14220003, 0, 0, 1, 0);  // BNE not taken
    run_instr(32'h00221821, 0, 0, 0, 0);
    run_instr(32'hAC220008, 2, 1, 0, 0);  // SW with stalls

    // Reset while the delay-slot fetch after a J is stalled
    run_instr(32'h08000010, 0, 0, 0, 0);
    waitrequest = 1;
    @(negedge clk);
    check_val("stall_fetch_rd", mem_read, 1);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rst_drop_rd", mem_read, 0);
    @(posedge clk); #1 reset = 0; waitrequest = 0;
    m_branch = 0; m_halt = 0;
    sync_fetch("rst_restart");
    run_instr(32'h00221821, 0, 0, 0, 0);  // pending target was discarded

    // JR $0 then NOP in the delay slot -> HALT
    run_instr(32'h00000008, 0, 0, 0, 1);
    run_instr(32'h00000000, 0, 0, 0, 0);
    check_halted();
    do_reset();

    for (int t = 0; t < 200; t++) begin
      logic [31:0] ins;
      int fs, ms;
      logic az, raz;
      ins = rand_instr(!m_branch && !m_halt);
      fs  = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 3));
      ms  = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 3));
      az  = 1'($urandom_range(0, 1));
      raz = ($urandom_range(0, 3) == 0);
      run_instr(ins, fs, ms, az, raz);
      if (!active) begin
        check_halted();
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
